vdc_pixel_shifter: RTL and testbench

//  Reader side of the VDC fetch buffers: consumes charbuf[] (char/bitmap pixel bytes) and attrbuf[rowbuf][] written
//  by the RAM interface, serialises them one dot per dot_en into 4-bit RGBI. Applies attributes (reverse,

---
 rtl/vdc_pixel_shifter.sv | 175 +++++++++++++++++
 tb/tb_vdc_pixel_shifter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vdc_pixel_shifter.sv
// VDC pixel shifter: serialises fetched char/bitmap bytes into RGBI dots,
// applying attributes, cursor, blink, semigraphics and reverse video.
module vdc_pixel_shifter #(
  parameter int C_LATCH_WIDTH = 8,
  parameter int S_LATCH_WIDTH = 82,
  parameter int C_LATCH_BITS  = $clog2(C_LATCH_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dot_en,
  input  logic                    newCol,
  input  logic                    newFrame,
  input  logic [7:0]              col,
  input  logic [4:0]              line,
  input  logic                    dispLine,
  input  logic                    rowbuf,
  input  logic [7:0]              charbuf [C_LATCH_WIDTH],
  input  logic [7:0]              attrbuf [2][S_LATCH_WIDTH],
  input  logic                    cursor_here,
  input  logic [7:0]              reg_hd,
  input  logic [3:0]              reg_cth,
  input  logic [3:0]              reg_cdh,
  input  logic [4:0]              reg_cdv,
  input  logic [4:0]              reg_ul,
  input  logic [1:0]              reg_cm,
  input  logic [4:0]              reg_crs,
  input  logic [4:0]              reg_cre,
  input  logic [3:0]              reg_fg,
  input  logic [3:0]              reg_bg,
  input  logic                    reg_atr,
  input  logic                    reg_text,
  input  logic                    reg_rvs,
  input  logic                    reg_semi,
  input  logic                    reg_blink,
  output logic [3:0]              rgbi,
  output logic                    de
);

  localparam int S_BITS = $clog2(S_LATCH_WIDTH);

  logic [7:0]              shift_q, shift_d;
  logic [7:0]              attr_q, attr_d;
  logic [3:0]              dc_q, dc_d;
  logic [C_LATCH_BITS-1:0] ri_q, ri_d, ri_nxt;
  logic [4:0]              blink_q, blink_d;
  logic                    active_q, active_d;
  logic                    vis_q, vis_d;
  logic                    cur_q, cur_d;
  logic                    last_q, last_d;
  logic [3:0]              rgbi_q, rgbi_d;
  logic                    de_q, de_d;

  logic                    load;
  logic                    col0;
  logic [S_BITS-1:0]       aidx;
  logic [7:0]              attr_w;
  logic                    in_cd;
  logic                    base;
  logic                    bphase;
  logic                    cmode;
  logic                    cur_on;
  logic                    pix;
  logic [3:0]              fg;

  assign col0 = dot_en && newCol && dispLine && (col == 8'd0);
  assign load = dot_en && newCol && dispLine && active_q
             && (col != 8'd0) && (col <= reg_hd);

  assign aidx   = S_BITS'(col - 8'd1);
  assign attr_w = (int'(col) <= S_LATCH_WIDTH) ? attrbuf[rowbuf][aidx] : 8'h00;

  assign ri_nxt = (ri_q == C_LATCH_BITS'(C_LATCH_WIDTH - 1))
                ? '0 : ri_q + C_LATCH_BITS'(1);

  always_comb begin
    ri_d     = ri_q;
    active_d = active_q;
    vis_d    = vis_q;
    shift_d  = shift_q;
    last_d   = last_q;
    attr_d   = attr_q;
    cur_d    = cur_q;
    dc_d     = dc_q;
    blink_d  = newFrame ? blink_q + 5'd1 : blink_q;
    if (dot_en) begin
      if (newCol) begin
        if (load) begin
          shift_d = charbuf[ri_q];
          last_d  = charbuf[ri_q][0];
          attr_d  = attr_w;
          cur_d   = cursor_here;
          ri_d    = ri_nxt;
          dc_d    = 4'd0;
          vis_d   = 1'b1;
        end else begin
          vis_d = 1'b0;
        end
        if (col0) begin
          ri_d     = '0;
          active_d = 1'b1;
        end
      end else begin
        if (dc_q < reg_cth) dc_d = dc_q + 4'd1;
        if (dc_q < 4'd7)    shift_d = {shift_q[6:0], 1'b0};
      end
    end
    if (!dispLine) begin
      active_d = 1'b0;
      vis_d    = 1'b0;
    end
  end

  // Pixel is formed from the post-update state so a load dot shows bit 7.
  always_comb begin
    in_cd = dc_d < reg_cdh;
    if ((dc_d < 4'd8) && in_cd)
      base = shift_d[7];
    else
      base = (dc_d <= reg_cth) && reg_semi && last_d;
    if (reg_atr && attr_d[5] && (line == reg_ul) && in_cd)
      base = 1'b1;
    bphase = reg_blink ? blink_q[4] : blink_q[3];
    if (reg_atr && attr_d[4] && !bphase)
      base = 1'b0;
    if (reg_text && (line > reg_cdv))
      base = 1'b0;
    unique case (reg_cm)
      2'b00:   cmode = 1'b1;
      2'b01:   cmode = 1'b0;
      2'b10:   cmode = blink_q[3];
      default: cmode = blink_q[4];
    endcase
    cur_on = cur_d && (line >= reg_crs) && (line <= reg_cre) && cmode;
    pix    = base ^ (reg_atr & attr_d[6]) ^ reg_rvs ^ cur_on;
    fg     = reg_atr ? attr_d[3:0] : reg_fg;
    rgbi_d = rgbi_q;
    de_d   = de_q;
    if (dot_en) begin
      de_d   = vis_d && dispLine;
      rgbi_d = (de_d && pix) ? fg : reg_bg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      attr_q   <= '0;
      dc_q     <= '0;
      ri_q     <= '0;
      blink_q  <= '0;
      active_q <= 1'b0;
      vis_q    <= 1'b0;
      cur_q    <= 1'b0;
      last_q   <= 1'b0;
      rgbi_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      attr_q   <= attr_d;
      dc_q     <= dc_d;
      ri_q     <= ri_d;
      blink_q  <= blink_d;
      active_q <= active_d;
      vis_q    <= vis_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      rgbi_q   <= rgbi_d;
      de_q     <= de_d;
    end
  end

  assign rgbi = rgbi_q;
  assign de   = de_q;

endmodule

// File: tb/tb_vdc_pixel_shifter.sv
// Randomised scoreboard bench for vdc_pixel_shifter; expected dots come
// from a per-column/per-dot model of the colour rules.
module tb_vdc_pixel_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dot_en, newCol, newFrame;
  logic [7:0] col;
  logic [4:0] line;
  logic       dispLine, rowbuf, cursor_here;
  logic [7:0] charbuf [8];
  logic [7:0] attrbuf [2][82];
  logic [7:0] reg_hd;
  logic [3:0] reg_cth, reg_cdh, reg_fg, reg_bg;
  logic [4:0] reg_cdv, reg_ul, reg_crs, reg_cre;
  logic [1:0] reg_cm;
  logic       reg_atr, reg_text, reg_rvs, reg_semi, reg_blink;
  logic [3:0] rgbi;
  logic       de;

  logic [4:0] q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         frames = 0;
  bit         curs [256];

  vdc_pixel_shifter dut (
    .clk(clk), .reset_n(reset_n), .dot_en(dot_en), .newCol(newCol),
    .newFrame(newFrame), .col(col), .line(line), .dispLine(dispLine),
    .rowbuf(rowbuf), .charbuf(charbuf), .attrbuf(attrbuf),
    .cursor_here(cursor_here), .reg_hd(reg_hd), .reg_cth(reg_cth),
    .reg_cdh(reg_cdh), .reg_cdv(reg_cdv), .reg_ul(reg_ul),
    .reg_cm(reg_cm), .reg_crs(reg_crs), .reg_cre(reg_cre),
    .reg_fg(reg_fg), .reg_bg(reg_bg), .reg_atr(reg_atr),
    .reg_text(reg_text), .reg_rvs(reg_rvs), .reg_semi(reg_semi),
    .reg_blink(reg_blink), .rgbi(rgbi), .de(de)
  );

  always #5 clk = ~clk;

  // Expected {de,rgbi} for dot k of column c.
  function automatic logic [4:0] exp_dot(input int c, input int k);
    logic [7:0] b, a;
    int bc;
    bit base, bp, on, con, p;
    logic [3:0] f;
    if (!dispLine || c == 0 || c > int'(reg_hd)) return {1'b0, reg_bg};
    b  = charbuf[(c - 1) % 8];
    a  = attrbuf[rowbuf][c - 1];
    bc = frames % 32;
    if (k < 8 && k < int'(reg_cdh)) base = b[7 - k];
    else base = reg_semi & b[0];
    if (reg_atr && a[5] && line == reg_ul && k < int'(reg_cdh)) base = 1;
    bp = reg_blink ? ((bc / 16) % 2 == 1) : ((bc / 8) % 2 == 1);
    if (reg_atr && a[4] && !bp) base = 0;
    if (reg_text && line > reg_cdv) base = 0;
    case (reg_cm)
      2'd0: on = 1;
      2'd1: on = 0;
      2'd2: on = ((bc / 8) % 2 == 1);
      default: on = ((bc / 16) % 2 == 1);
    endcase
    con = curs[c] && line >= reg_crs && line <= reg_cre && on;
    p = base ^ (reg_atr & a[6]) ^ reg_rvs ^ con;
    f = reg_atr ? a[3:0] : reg_fg;
    return {1'b1, p ? f : reg_bg};
  endfunction

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(posedge clk);
      if (reset_n && dot_en) begin
        #1;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL underflow: DUT de=%0b rgbi=%h with nothing expected",
                   de, rgbi);
        end else begin
          e = q.pop_front();
          if ({de, rgbi} !== e) begin
            n_bad++;
            $display("FAIL dot col=%0d line=%0d: got de=%0b rgbi=%h want de=%0b rgbi=%h",
                     col, line, de, rgbi, e[4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic rand_regs(input int hd);
    reg_hd    = 8'(hd);
    reg_cth   = 4'($urandom_range(7, 11));
    reg_cdh   = 4'($urandom_range(0, 12));
    line      = 5'($urandom_range(0, 15));
    reg_cdv   = 5'($urandom_range(0, 20));
    reg_ul    = ($urandom_range(0, 1) == 1) ? line : 5'($urandom);
    reg_crs   = 5'($urandom_range(0, 12));
    reg_cre   = 5'($urandom_range(4, 31));
    reg_cm    = 2'($urandom);
    reg_fg    = 4'($urandom);
    reg_bg    = 4'($urandom);
    reg_atr   = 1'($urandom);
    reg_text  = 1'($urandom);
    reg_rvs   = ($urandom_range(0, 3) == 0);
    reg_semi  = 1'($urandom);
    reg_blink = 1'($urandom);
    rowbuf    = 1'($urandom);
    for (int i = 0; i < 8; i++) charbuf[i] = 8'($urandom);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 82; i++) attrbuf[r][i] = 8'($urandom);
    for (int i = 0; i < 256; i++) curs[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_line(input bit disp, input int stop_col);
    dispLine = disp;
    for (int c = 0; c <= int'(reg_hd) + 1 && c <= stop_col; c++) begin
      for (int k = 0; k <= int'(reg_cth); k++) begin
        repeat ($urandom_range(0, 1)) begin
          @(negedge clk);
          dot_en = 0; newCol = 0; cursor_here = 1'($urandom);
        end
        @(negedge clk);
        dot_en = 1;
        newCol = (k == 0);
        col = 8'(c);
        cursor_here = (k == 0) ? curs[c] : 1'($urandom);
        q.push_back(exp_dot(c, k));
      end
    end
    @(negedge clk);
    dot_en = 0; newCol = 0;
  endtask

  task automatic frame_pulse();
    @(negedge clk); newFrame = 1;
    @(negedge clk); newFrame = 0;
    frames++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d dots still pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset(input string nm);
    n_cmp++;
    if (rgbi !== 4'h0 || de !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got de=%0b rgbi=%h want de=0 rgbi=0", nm, de, rgbi);
    end
  endtask

  initial begin
    reset_n = 0; dot_en = 0; newCol = 0; newFrame = 0; col = 0;
    dispLine = 0; cursor_here = 0;
    rand_regs(4);
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    reset_n = 1;

    rand_regs(80);
    reg_cdh = 4'd8; reg_cth = 4'd7;
    run_line(1, 1000);
    frame_pulse();

    for (int n = 0; n < 44; n++) begin
      rand_regs($urandom_range(1, 20));
      run_line($urandom_range(0, 9) != 0, 1000);
      frame_pulse();
      if ($urandom_range(0, 3) == 0) frame_pulse();
    end

    rand_regs(12);
    reg_bg = 4'hA; reg_rvs = 1;
    run_line(1, 3);
    drain();
    @(negedge clk);
    reset_n = 0;
    #1;
    check_reset("reset_midline");
    frames = 0;
    @(negedge clk);
    reset_n = 1;

    for (int n = 0; n < 6; n++) begin
      rand_regs($urandom_range(1, 16));
      run_line(1, 1000);
      frame_pulse();
    end

    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
